// File: rtl/mw_cook_ctrl_param.sv
// Parametrised microwave cook controller: N-digit MM..SS entry, duty-cycled power,
// pause/resume, and a timed done alarm driving a 7-segment display bank.
module mw_cook_ctrl_param #(
  parameter int DIGITS        = 4,
  parameter int TICKS_PER_SEC = 100,
  parameter int PWR_MAX       = 10,
  parameter int DONE_SECS     = 3
) (
  input  logic                         clk,
  input  logic                         clearn,
  input  logic [9:0]                   keypad,
  input  logic                         startn,
  input  logic                         stopn,
  input  logic                         door_closed,
  input  logic [$clog2(PWR_MAX+1)-1:0] power_sel,
  output logic                         mag_on,
  output logic                         done,
  output logic                         cooking,
  output logic [7*DIGITS-1:0]          segs
);

  localparam int PW   = $clog2(PWR_MAX + 1);
  localparam int CW   = $clog2(TICKS_PER_SEC + 1);
  localparam int DW   = $clog2(DONE_SECS + 1);
  localparam int STEP = TICKS_PER_SEC / PWR_MAX;

  typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      digit   [DIGITS];
  logic [3:0]      digit_n [DIGITS];
  logic [3:0]      dec     [DIGITS];
  logic [CW-1:0]   tick_cnt, tick_n, tick_inc, thresh;
  logic [PW-1:0]   power, power_n, power_clamp;
  logic [DW-1:0]   done_cnt, done_cnt_n;
  logic            startn_q, stopn_q;
  logic [9:0]      keypad_q;
  logic            start_ev, stop_ev, key_ev, key_onehot;
  logic [3:0]      key_val;
  logic            time_zero, dec_zero, tick_wrap, borrow;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= S_IDLE;
      digit    <= '{default: '0};
      tick_cnt <= '0;
      power    <= '0;
      done_cnt <= '0;
      startn_q <= 1'b0;
      stopn_q  <= 1'b0;
      keypad_q <= '0;
    end else begin
      state    <= state_n;
      digit    <= digit_n;
      tick_cnt <= tick_n;
      power    <= power_n;
      done_cnt <= done_cnt_n;
      startn_q <= startn;
      stopn_q  <= stopn;
      keypad_q <= keypad;
    end
  end

  always_comb begin
    start_ev   = startn_q & ~startn;
    stop_ev    = stopn_q & ~stopn;
    key_onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    key_ev     = (keypad != keypad_q) && key_onehot;
    key_val    = '0;
    for (int k = 0; k < 10; k++)
      if (keypad[k]) key_val = 4'(k);

    tick_wrap = (tick_cnt == CW'(TICKS_PER_SEC - 1));
    tick_inc  = tick_wrap ? '0 : tick_cnt + 1'b1;

    if (power_sel == '0)                 power_clamp = PW'(1);
    else if (power_sel > PW'(PWR_MAX))   power_clamp = PW'(PWR_MAX);
    else                                 power_clamp = power_sel;

    // Seconds 00 borrows from the BCD minutes and reloads as 59.
    dec    = digit;
    borrow = 1'b0;
    if (digit[0] != 4'd0) begin
      dec[0] = digit[0] - 4'd1;
    end else begin
      dec[0] = 4'd9;
      if (digit[1] != 4'd0) begin
        dec[1] = digit[1] - 4'd1;
      end else begin
        dec[1] = 4'd5;
        borrow = 1'b1;
      end
    end
    for (int i = 2; i < DIGITS; i++) begin
      if (borrow) begin
        if (digit[i] != 4'd0) begin
          dec[i] = digit[i] - 4'd1;
          borrow = 1'b0;
        end else begin
          dec[i] = 4'd9;
        end
      end
    end

    time_zero = 1'b1;
    dec_zero  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit[i] != 4'd0) time_zero = 1'b0;
      if (dec[i] != 4'd0)   dec_zero  = 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    digit_n    = digit;
    tick_n     = tick_cnt;
    power_n    = power;
    done_cnt_n = done_cnt;
    case (state)
      S_IDLE: begin
        if (stop_ev) begin
          digit_n = '{default: '0};
        end else if (start_ev) begin
          if (!time_zero && door_closed) begin
            state_n = S_COOK;
            tick_n  = '0;
            power_n = power_clamp;
          end
        end else if (key_ev) begin
          for (int i = DIGITS - 1; i > 0; i--) digit_n[i] = digit[i-1];
          digit_n[0] = key_val;
        end
      end
      S_COOK: begin
        if (!door_closed || stop_ev) begin
          state_n = S_PAUSE;
        end else begin
          tick_n = tick_inc;
          if (tick_wrap) begin
            digit_n = dec;
            if (dec_zero) begin
              state_n    = S_DONE;
              tick_n     = '0;
              done_cnt_n = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_ev) begin
          state_n = S_IDLE;
          digit_n = '{default: '0};
        end else if (start_ev && door_closed) begin
          state_n = S_COOK;
        end
      end
      S_DONE: begin
        if (key_ev || start_ev || stop_ev) begin
          state_n = S_IDLE;
        end else begin
          tick_n = tick_inc;
          if (tick_wrap) begin
            if (done_cnt == DW'(DONE_SECS - 1)) state_n = S_IDLE;
            else                                done_cnt_n = done_cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Power sets how many ticks of each second the magnetron is driven.
  assign thresh  = CW'(power) * CW'(STEP);
  assign mag_on  = (state == S_COOK) && door_closed && (tick_cnt < thresh);
  assign cooking = (state == S_COOK);
  assign done    = (state == S_DONE);

  always_comb begin
    segs = '0;
    for (int i = 0; i < DIGITS; i++) segs[7*i +: 7] = seg7(digit[i]);
  end

endmodule

// File: tb/tb_mw_cook_ctrl_param.sv
// Directed bench for mw_cook_ctrl_param (4 digits, 100 ticks/s, 10 power levels, 3 s alarm).
module tb_mw_cook_ctrl_param;

  logic        clk = 1'b0;
  logic        clearn;
  logic [9:0]  keypad;
  logic        startn, stopn, door_closed;
  logic [3:0]  power_sel;
  logic        mag_on, done, cooking;
  logic [27:0] segs;

  int n_asserts = 0;
  int n_fail    = 0;

  mw_cook_ctrl_param dut (
    .clk(clk), .clearn(clearn), .keypad(keypad), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .power_sel(power_sel), .mag_on(mag_on), .done(done),
    .cooking(cooking), .segs(segs)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: seg7 = 7'h3F;  1: seg7 = 7'h06;  2: seg7 = 7'h5B;  3: seg7 = 7'h4F;
      4: seg7 = 7'h66;  5: seg7 = 7'h6D;  6: seg7 = 7'h7D;  7: seg7 = 7'h07;
      8: seg7 = 7'h7F;  9: seg7 = 7'h6F;  default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] disp(input int m1, input int m0, input int s1, input int s0);
    disp = {seg7(m1), seg7(m0), seg7(s1), seg7(s0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    keypad = 10'(1 << k);
    tick(1);
    keypad = '0;
    tick(1);
  endtask

  task automatic press_start();
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    tick(1);
    stopn = 1'b1;
    tick(1);
  endtask

  initial begin
    clearn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; power_sel = 4'd10;
    tick(3);
    chk("reset_segs", 32'(segs), 32'(disp(0, 0, 0, 0)));
    chk("reset_mag", 32'(mag_on), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cooking", 32'(cooking), 32'd0);
    clearn = 1'b1;
    tick(1);

    // Entry 12:34 at full power, one-second countdown
    press_key(1); press_key(2); press_key(3); press_key(4);
    chk("entry_1234", 32'(segs), 32'(disp(1, 2, 3, 4)));
    press_start();
    chk("t1_cooking", 32'(cooking), 32'd1);
    chk("t1_mag_t0", 32'(mag_on), 32'd1);
    tick(99);
    chk("t1_segs_t99", 32'(segs), 32'(disp(1, 2, 3, 4)));
    chk("t1_mag_t99", 32'(mag_on), 32'd1);
    tick(1);
    chk("t1_segs_1233", 32'(segs), 32'(disp(1, 2, 3, 3)));

    // Stop pauses, second stop clears, start at zero ignored
    press_stop();
    chk("t5_pause_cooking", 32'(cooking), 32'd0);
    chk("t5_pause_mag", 32'(mag_on), 32'd0);
    chk("t5_pause_segs", 32'(segs), 32'(disp(1, 2, 3, 3)));
    press_stop();
    chk("t5_clear_segs", 32'(segs), 32'(disp(0, 0, 0, 0)));
    press_start();
    chk("t5_zero_start", 32'(cooking), 32'd0);
    tick(1);

    // 1:00 borrow and full countdown into the done alarm
    press_key(1); press_key(0); press_key(0);
    chk("t2_entry", 32'(segs), 32'(disp(0, 1, 0, 0)));
    press_start();
    tick(99);
    chk("t2_segs_pre", 32'(segs), 32'(disp(0, 1, 0, 0)));
    tick(1);
    chk("t2_borrow_059", 32'(segs), 32'(disp(0, 0, 5, 9)));
    tick(5899);
    chk("t2_segs_001", 32'(segs), 32'(disp(0, 0, 0, 1)));
    chk("t2_still_cooking", 32'(cooking), 32'd1);
    tick(1);
    chk("t2_done_on", 32'(done), 32'd1);
    chk("t2_done_cooking", 32'(cooking), 32'd0);
    chk("t2_done_mag", 32'(mag_on), 32'd0);
    chk("t2_done_segs", 32'(segs), 32'(disp(0, 0, 0, 0)));
    tick(299);
    chk("t2_done_last", 32'(done), 32'd1);
    tick(1);
    chk("t2_done_off", 32'(done), 32'd0);
    chk("t2_idle_mag", 32'(mag_on), 32'd0);

    // Power 3: magnetron on for ticks 0..29 only; power latched at start
    press_key(5);
    power_sel = 4'd3;
    press_start();
    power_sel = 4'd10;
    chk("t3_mag_t0", 32'(mag_on), 32'd1);
    tick(29);
    chk("t3_mag_t29", 32'(mag_on), 32'd1);
    tick(1);
    chk("t3_mag_t30", 32'(mag_on), 32'd0);
    tick(69);
    chk("t3_mag_t99", 32'(mag_on), 32'd0);
    tick(1);
    chk("t3_mag_wrap", 32'(mag_on), 32'd1);
    chk("t3_segs_004", 32'(segs), 32'(disp(0, 0, 0, 4)));

    // Door opens mid-second: immediate drop, pause, resume at same tick
    tick(20);
    chk("t4_mag_t20", 32'(mag_on), 32'd1);
    door_closed = 1'b0;
    #1;
    chk("t4_mag_door", 32'(mag_on), 32'd0);
    tick(1);
    chk("t4_paused", 32'(cooking), 32'd0);
    tick(200);
    chk("t4_frozen", 32'(segs), 32'(disp(0, 0, 0, 4)));
    door_closed = 1'b1;
    tick(1);
    chk("t4_mag_closed_pause", 32'(mag_on), 32'd0);
    press_start();
    chk("t4_resumed", 32'(cooking), 32'd1);
    chk("t4_mag_t20r", 32'(mag_on), 32'd1);
    tick(9);
    chk("t4_mag_t29", 32'(mag_on), 32'd1);
    tick(1);
    chk("t4_mag_t30", 32'(mag_on), 32'd0);
    tick(69);
    chk("t4_segs_t99", 32'(segs), 32'(disp(0, 0, 0, 4)));
    tick(1);
    chk("t4_segs_003", 32'(segs), 32'(disp(0, 0, 0, 3)));

    // Asynchronous clear mid-cook
    clearn = 1'b0;
    #1;
    chk("t6_rst_cooking", 32'(cooking), 32'd0);
    chk("t6_rst_mag", 32'(mag_on), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_segs", 32'(segs), 32'(disp(0, 0, 0, 0)));
    tick(2);
    clearn = 1'b1;
    tick(1);

    // Multi-hot keypad ignored, single key accepted
    keypad = 10'b0000000110;
    tick(1);
    keypad = '0;
    tick(1);
    chk("t6_multihot", 32'(segs), 32'(disp(0, 0, 0, 0)));
    press_key(7);
    chk("t6_key7", 32'(segs), 32'(disp(0, 0, 0, 7)));

    // Start with door open ignored; power 0 clamps to level 1
    door_closed = 1'b0;
    press_start();
    tick(1);
    chk("door_open_start", 32'(cooking), 32'd0);
    door_closed = 1'b1;
    power_sel = 4'd0;
    press_start();
    chk("clamp_cooking", 32'(cooking), 32'd1);
    chk("clamp_mag_t0", 32'(mag_on), 32'd1);
    tick(9);
    chk("clamp_mag_t9", 32'(mag_on), 32'd1);
    tick(1);
    chk("clamp_mag_t10", 32'(mag_on), 32'd0);
    press_key(3);
    chk("cook_key_ignored", 32'(segs), 32'(disp(0, 0, 0, 7)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
